// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine.
// Holds the arctangent table at 32-bit angle precision and its rescaling helper.
package cordic_pkg;

  typedef enum logic {
    CORDIC_ROT = 1'b0,
    CORDIC_VEC = 1'b1
  } cordic_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } cordic_state_e;

  // CORDIC gain K and its reciprocal, both as Q2.30 fixed point.
  localparam logic [31:0] K_Q30     = 32'd1768195365;
  localparam logic [31:0] INV_K_Q30 = 32'd652032874;

  // round(atan(2^-i) * 2^32 / (2*pi)); full circle = 2^32.
  localparam logic [31:0] ATAN_TABLE [0:31] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  // Rescale a 32-bit-turn angle to angle_w bits (round-half-up when narrowing).
  function automatic logic [63:0] atan_scale(input logic [31:0] t, input int angle_w);
    logic [63:0] wide;
    wide = {32'd0, t};
    if (angle_w <= 32)
      return (wide + ((64'd1 << (32 - angle_w)) >> 1)) >> (32 - angle_w);
    else
      return wide << (angle_w - 32);
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational lookup of the per-iteration arctangent step at ANGLE_W bits.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int ANGLE_W = 32
) (
  input  logic [4:0]         idx,
  output logic [ANGLE_W-1:0] atan
);

  always_comb begin
    atan = ANGLE_W'(atan_scale(ATAN_TABLE[idx], ANGLE_W));
  end

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: rotation (cos/sin) and vectoring (magnitude/atan2) modes,
// full-circle range through quadrant pre-rotation, one micro-rotation per cycle.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ANGLE_W = 32,
  parameter int ITERS   = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [DATA_W-1:0]   in_x,
  input  logic [DATA_W-1:0]   in_y,
  input  logic [ANGLE_W-1:0]  in_z,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_x,
  output logic [DATA_W-1:0]   out_y,
  output logic [ANGLE_W-1:0]  out_z,
  output cordic_state_e       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; out_valid and the outputs hold steady until out_ready is seen high.

  // Two guard bits cover K*sqrt(2) growth and negation of the most negative input.
  localparam int XW = DATA_W + 2;
  localparam logic [ANGLE_W-1:0] HALF_TURN = {1'b1, {(ANGLE_W-1){1'b0}}};

  cordic_state_e            state, state_nxt;
  cordic_mode_e             mode;
  logic [4:0]               cnt;
  logic signed [XW-1:0]     x, y;
  logic [ANGLE_W-1:0]       z;
  logic signed [XW-1:0]     x_ext, y_ext, x_pre, y_pre;
  logic [ANGLE_W-1:0]       z_pre;
  logic signed [XW-1:0]     x_sh, y_sh, x_nxt, y_nxt;
  logic [ANGLE_W-1:0]       z_nxt, atan;
  logic                     d_pos, last, accept;

  function automatic logic [DATA_W-1:0] sat(input logic signed [XW-1:0] v);
    if ((&v[XW-1:DATA_W-1]) || !(|v[XW-1:DATA_W-1]))
      return v[DATA_W-1:0];
    else if (v[XW-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  cordic_atan_rom #(.ANGLE_W(ANGLE_W)) u_rom (
    .idx  (cnt),
    .atan (atan)
  );

  assign x_ext = {{2{in_x[DATA_W-1]}}, in_x};
  assign y_ext = {{2{in_y[DATA_W-1]}}, in_y};

  // Fold the operand into the right half-plane so the micro-rotations converge.
  always_comb begin
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = in_z;
    if (in_mode == CORDIC_VEC) begin
      z_pre = '0;
      if (in_x[DATA_W-1]) begin
        x_pre = -x_ext;
        y_pre = -y_ext;
        z_pre = HALF_TURN;
      end
    end else if (in_z[ANGLE_W-1] ^ in_z[ANGLE_W-2]) begin
      x_pre = -x_ext;
      y_pre = -y_ext;
      z_pre = in_z ^ HALF_TURN;
    end
  end

  always_comb begin
    x_sh  = x >>> cnt;
    y_sh  = y >>> cnt;
    d_pos = (mode == CORDIC_ROT) ? ~z[ANGLE_W-1] : y[XW-1];
    if (d_pos) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan;
    end
  end

  assign last = (cnt == 5'(ITERS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_ITER;
      end
      S_ITER: begin
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? S_ITER : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (reset) in_ready = 1'b0;
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode  <= CORDIC_ROT;
      cnt   <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      out_x <= '0;
      out_y <= '0;
      out_z <= '0;
    end else if (accept) begin
      mode <= cordic_mode_e'(in_mode);
      cnt  <= '0;
      x    <= x_pre;
      y    <= y_pre;
      z    <= z_pre;
    end else if (state == S_ITER) begin
      x   <= x_nxt;
      y   <= y_nxt;
      z   <= z_nxt;
      cnt <= cnt + 5'd1;
      if (last) begin
        out_x <= sat(x_nxt);
        out_y <= sat(y_nxt);
        out_z <= z_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Directed bench for cordic_engine: scoreboard fed at accept, checked by an output monitor.
module tb_cordic_engine;
  import cordic_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IT = 24;
  localparam logic [31:0] A = INV_K_Q30;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [15:0] tol;
  } exp_t;

  typedef struct packed {
    logic  mode;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    exp_t  e;
  } vec_t;

  logic          clk, reset;
  logic          in_valid, in_ready, in_mode;
  logic [DW-1:0] in_x, in_y;
  logic [AW-1:0] in_z;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_x, out_y;
  logic [AW-1:0] out_z;
  cordic_state_e dbg_state;

  cordic_engine #(.DATA_W(DW), .ANGLE_W(AW), .ITERS(IT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  exp_t cur_exp;
  int   n_vec = 0;
  int   n_fail = 0;
  int   acc_cnt = 0;
  int   acc_cyc = 0;
  int   prev_acc_cyc = 0;
  int   out_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp, input longint tol);
    n_vec++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  // Accept monitor: the edge after this negedge transfers the operand.
  always @(negedge clk) begin
    if (!reset && in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      acc_cnt++;
      prev_acc_cyc = acc_cyc;
      acc_cyc = cyc;
    end
  end

  // Output monitor.
  exp_t        mon_e;
  logic [31:0] zdiff;
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_output: got x=%0d y=%0d z=%h with nothing expected",
                 $signed(out_x), $signed(out_y), out_z);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_x", longint'($signed(out_x)), longint'($signed(mon_e.x)), longint'(mon_e.tol));
        check("out_y", longint'($signed(out_y)), longint'($signed(mon_e.y)), longint'(mon_e.tol));
        zdiff = out_z - mon_e.z;
        check("out_z_err", longint'($signed(zdiff)), 0, longint'(mon_e.tol));
        out_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    cur_exp  = v.e;
    in_mode  = v.mode;
    in_x     = v.x;
    in_y     = v.y;
    in_z     = v.z;
  endtask

  task automatic send(input vec_t v);
    int start;
    int k;
    drive(v);
    in_valid = 1'b1;
    start = acc_cnt;
    k = 0;
    while (acc_cnt == start && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    in_valid = 1'b0;
    if (acc_cnt == start) check("accept_timeout", k, 0, 0);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_pending", exp_q.size(), 0, 0);
  endtask

  // ---------------- stimulus ----------------
  // Tolerance: residual angle after 24 steps is below ATAN[23]=81/2^32 turn,
  // worth ~130 LSB at 2^30 magnitude; large vectoring inputs get a wider bound.
  vec_t vecs [9];
  vec_t v45, v90;
  int   k;
  int   a0;
  int   n_expected;
  logic stable;
  logic [31:0] sx, sy, sz;

  initial begin
    vecs[0] = '{1'b0, A, 32'd0, 32'h00000000, '{32'd1073741824, 32'd0, 32'd0, 16'd256}};
    vecs[1] = '{1'b0, A, 32'd0, 32'h20000000, '{32'd759250125, 32'd759250125, 32'd0, 16'd256}};
    vecs[2] = '{1'b0, A, 32'd0, 32'h40000000, '{32'd0, 32'd1073741824, 32'd0, 16'd256}};
    vecs[3] = '{1'b0, A, 32'd0, 32'h80000000, '{32'hC0000000, 32'd0, 32'd0, 16'd256}};
    vecs[4] = '{1'b0, A, 32'd0, 32'hC0000000, '{32'd0, 32'hC0000000, 32'd0, 16'd256}};
    vecs[5] = '{1'b1, 32'h20000000, 32'h20000000, 32'd0, '{32'd1250302932, 32'd0, 32'h20000000, 16'd256}};
    vecs[6] = '{1'b1, 32'hE0000000, 32'd0, 32'd0, '{32'd884097683, 32'd0, 32'h80000000, 16'd256}};
    vecs[7] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, '{32'h7FFFFFFF, 32'd0, 32'h20000000, 16'd1024}};
    vecs[8] = '{1'b1, 32'h80000000, 32'd0, 32'd0, '{32'h7FFFFFFF, 32'd0, 32'h80000000, 16'd1024}};
    v45 = vecs[1];
    v90 = vecs[2];
    n_expected = 0;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_z      = '0;
    out_ready = 1'b1;
    cur_exp   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 0, 0);
    check("reset_out_valid", out_valid, 0, 0);
    check("reset_out_x", out_x, 0, 0);
    check("reset_out_z", out_z, 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("release_in_ready", in_ready, 1, 0);

    // Latency from accept edge to out_valid.
    send(v45);
    n_expected++;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", k, IT, 0);
    wait_drain();

    for (int i = 0; i < 9; i++) begin
      send(vecs[i]);
      n_expected++;
      wait_drain();
    end

    // Backpressure: result must hold while out_ready is low; new operand ignored.
    out_ready = 1'b0;
    send(v45);
    n_expected++;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    sx = out_x;
    sy = out_y;
    sz = out_z;
    a0 = acc_cnt;
    drive(v90);
    in_valid = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_x !== sx || out_y !== sy || out_z !== sz || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    check("bp_stable", stable, 1, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_no_accept", acc_cnt, a0, 0);
    out_ready = 1'b1;
    wait_drain();

    // Back-to-back: accept in the DONE cycle gives a 25-cycle period.
    drive(v45);
    a0 = acc_cnt;
    in_valid = 1'b1;
    k = 0;
    while (acc_cnt < a0 + 3 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1 in_valid = 1'b0;
    n_expected += 3;
    check("b2b_accepts", acc_cnt - a0, 3, 0);
    check("b2b_period", acc_cyc - prev_acc_cyc, IT + 1, 0);
    wait_drain();

    // Reset in the middle of an operation (counter = 10).
    send(v45);
    repeat (10) @(posedge clk);
    #1;
    check("inflight_count", exp_q.size(), 1, 0);
    reset = 1'b1;
    #1;
    check("midreset_out_valid", out_valid, 0, 0);
    check("midreset_out_x", out_x, 0, 0);
    check("midreset_out_y", out_y, 0, 0);
    check("midreset_out_z", out_z, 0, 0);
    check("midreset_in_ready", in_ready, 0, 0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1, 0);
    check("post_reset_state", dbg_state, S_IDLE, 0);
    send(v45);
    n_expected++;
    wait_drain();

    repeat (5) @(posedge clk);
    check("result_count", out_cnt, n_expected, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
